// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, instruction
// fields, exception causes, PC source selects and ALU operation classes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST = 3'd0,
    ST_IF  = 3'd1,
    ST_ID  = 3'd2,
    ST_EX  = 3'd3,
    ST_MEM = 3'd4,
    ST_WB  = 3'd5,
    ST_EXC = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ERET = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] CAUSE_IRQ     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_OVF     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [2:0] PCS_ALU    = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_EXC    = 3'b011;
  localparam logic [2:0] PCS_EPC    = 3'b100;
  localparam logic [2:0] PCS_RS     = 3'b101;

  localparam logic [2:0] ALU_CLS_ADD   = 3'b000;
  localparam logic [2:0] ALU_CLS_BEQ   = 3'b001;
  localparam logic [2:0] ALU_CLS_RTYPE = 3'b010;
  localparam logic [2:0] ALU_CLS_AND   = 3'b100;
  localparam logic [2:0] ALU_CLS_SLT   = 3'b101;

  // R-type functs that compute a result and retire through WB
  function automatic logic is_alu_funct(input logic [5:0] f);
    logic ok;
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_shift_funct(input logic [5:0] f);
    return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
  endfunction

endpackage

// File: rtl/mc_irq_prio.sv
// Lowest-index-wins priority encoder turning the interrupt request
// vector into a one-hot acknowledge pattern.
module mc_irq_prio #(
  parameter int IRQ_N = 4
) (
  input  logic [IRQ_N-1:0] irq,
  output logic [IRQ_N-1:0] irq_ack
);

  // Scan from the top so the lowest asserted index is the last writer.
  always_comb begin
    irq_ack = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_ack    = '0;
        irq_ack[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_controller_v2.sv
// Multi-cycle control unit: fetch/decode/execute/memory/writeback sequencing
// with memory timeout, overflow trap, illegal-instruction trap and interrupts.
//
// state | meaning
// RST   | held in reset; all outputs low
// IF    | instruction fetch, waits for mem_ready
// ID    | decode, branch target computed
// EX    | execute / jumps / eret
// MEM   | data access for lw/sw, waits for mem_ready
// WB    | register writeback, overflow trap check
// EXC   | exception entry: save EPC and cause, jump to vector
module mc_controller_v2
  import mc_ctrl_pkg::*;
#(
  parameter int IRQ_N       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             alu_overflow,
  input  logic [IRQ_N-1:0] irq,
  input  logic             irq_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             ext_op,
  output logic             lui_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       pc_source,
  output logic             epc_write,
  output logic             cause_write,
  output logic             kernel_mode,
  output logic [1:0]       cause,
  output logic [IRQ_N-1:0] irq_ack
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       kmode_q, kmode_d;
  logic [7:0] tmo_q, tmo_d;

  logic [IRQ_N-1:0] ack_vec;
  logic [2:0]       alu_cls;
  logic             is_r, tmo_hit, take_irq, ovf_trap, to_if;

  mc_irq_prio #(.IRQ_N(IRQ_N)) u_irq_prio (
    .irq     (irq),
    .irq_ack (ack_vec)
  );

  assign is_r        = (opcode == OP_RTYPE);
  assign tmo_hit     = (tmo_q == TMO_LAST);
  assign take_irq    = irq_en && (|irq) && !kmode_q;
  assign ovf_trap    = alu_overflow &&
                       ((opcode == OP_ADDI) || (is_r && ((funct == FN_ADD) || (funct == FN_SUB))));
  assign kernel_mode = kmode_q;

  always_comb begin
    alu_cls = ALU_CLS_ADD;
    if (is_r)                                         alu_cls = ALU_CLS_RTYPE;
    else if (opcode == OP_BEQ)                        alu_cls = ALU_CLS_BEQ;
    else if (opcode == OP_ANDI)                       alu_cls = ALU_CLS_AND;
    else if (opcode == OP_SLTI || opcode == OP_SLTIU) alu_cls = ALU_CLS_SLT;
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    kmode_d       = kmode_q;
    to_if         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    ext_op        = 1'b0;
    lui_op        = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    pc_source     = PCS_ALU;
    epc_write     = 1'b0;
    cause_write   = 1'b0;
    cause         = 2'b00;
    irq_ack       = '0;

    if (state_q != ST_RST) alu_op[3] = opcode[0];
    if (state_q == ST_EX || state_q == ST_MEM || state_q == ST_WB) alu_op[2:0] = alu_cls;

    case (state_q)
      ST_RST: state_d = ST_IF;

      ST_IF: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_ID;
        end else if (tmo_hit) begin
          state_d = ST_EXC;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_ID: begin
        alu_src_b = 2'b11;
        state_d   = ST_EX;
      end

      ST_EX: begin
        case (opcode)
          OP_J: begin
            pc_write  = 1'b1;
            pc_source = PCS_JUMP;
            to_if     = 1'b1;
          end
          OP_JAL: begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            pc_source  = PCS_JUMP;
            to_if      = 1'b1;
          end
          OP_BEQ: begin
            pc_write_cond = 1'b1;
            alu_src_a     = 2'b01;
            pc_source     = PCS_ALUOUT;
            to_if         = 1'b1;
          end
          OP_RTYPE: begin
            if (funct == FN_JR || funct == FN_JALR) begin
              pc_write  = 1'b1;
              pc_source = PCS_RS;
              to_if     = 1'b1;
              if (funct == FN_JALR) begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b10;
              end
            end else if (is_alu_funct(funct)) begin
              alu_src_a = is_shift_funct(funct) ? 2'b10 : 2'b01;
              state_d   = ST_WB;
            end else begin
              state_d = ST_EXC;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          OP_COP0: begin
            if (funct == FN_ERET) begin
              pc_write  = 1'b1;
              pc_source = PCS_EPC;
              kmode_d   = 1'b0;
              to_if     = 1'b1;
            end else begin
              state_d = ST_EXC;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          OP_LW, OP_SW: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            state_d   = ST_MEM;
          end
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            ext_op    = (opcode != OP_ANDI);
            lui_op    = (opcode == OP_LUI);
            state_d   = ST_WB;
          end
          default: begin
            state_d = ST_EXC;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) to_if   = 1'b1;
          else                 state_d = ST_WB;
        end else if (tmo_hit) begin
          state_d = ST_EXC;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_WB: begin
        if (opcode == OP_LW) begin
          mem_to_reg = 2'b01;
        end else if (is_r) begin
          reg_dst = 2'b01;
        end
        if (ovf_trap) begin
          state_d = ST_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          reg_write = 1'b1;
          to_if     = 1'b1;
        end
      end

      ST_EXC: begin
        epc_write   = 1'b1;
        cause_write = 1'b1;
        cause       = cause_q;
        pc_write    = 1'b1;
        pc_source   = PCS_EXC;
        if (cause_q == CAUSE_IRQ) irq_ack = ack_vec;
        kmode_d     = 1'b1;
        state_d     = ST_IF;
      end

      default: state_d = ST_RST;
    endcase

    // Retiring instructions divert to the interrupt entry instead of IF.
    if (to_if) begin
      if (take_irq) begin
        state_d = ST_EXC;
        cause_d = CAUSE_IRQ;
      end else begin
        state_d = ST_IF;
      end
    end

    tmo_d = (state_d == state_q) ? tmo_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      cause_q <= 2'b00;
      kmode_q <= 1'b0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      kmode_q <= kmode_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
